// File: rtl/block_serial_subtractor.sv
// =============================================================================
// block_serial_subtractor
//   Multi-cycle subtractor: D = A - B - borrow_in, one BLOCK_WIDTH slice per
//   clock, LSB slice first, with a registered borrow between slices.
//   Optional macro SUB_SAT_EN: unsigned saturation of the result to zero.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module block_serial_subtractor #(
  parameter int WIDTH       = 16,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iBorrow,
  output logic             oBusy,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oD,
  output logic             oBorrow,
  output logic             oZero,
  output logic             oOvf
);

  localparam int N     = WIDTH / BLOCK_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   accept;
  logic                   last_slice;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [WIDTH-1:0]       d_reg;
  logic [WIDTH-1:0]       d_next;
  logic                   borrow_reg;
  logic                   zero_reg;
  logic                   ovf_reg;
  logic [BLOCK_WIDTH-1:0] a_slice;
  logic [BLOCK_WIDTH-1:0] b_slice;
  logic [BLOCK_WIDTH:0]   slice_sum;

  assign last_slice = (cnt == CNT_W'(N - 1));

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new command is accepted from IDLE, or from DONE in the same cycle the
  // result is consumed, so back-to-back operations need no idle bubble.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (iReady) begin
          if (iStart) begin
            accept     = 1'b1;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction as A + ~B + ~borrow; the slice carry-out is the inverted borrow.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt == CNT_W'(k)) begin
        a_slice = a_reg[k*BLOCK_WIDTH +: BLOCK_WIDTH];
        b_slice = b_reg[k*BLOCK_WIDTH +: BLOCK_WIDTH];
      end
    end
    slice_sum = {1'b0, a_slice} + {1'b0, ~b_slice} + {{BLOCK_WIDTH{1'b0}}, ~borrow_reg};
    d_next    = d_reg;
    for (int k = 0; k < N; k++) begin
      if (cnt == CNT_W'(k)) begin
        d_next[k*BLOCK_WIDTH +: BLOCK_WIDTH] = slice_sum[BLOCK_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      cnt        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      d_reg      <= '0;
      borrow_reg <= 1'b0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (accept) begin
      a_reg      <= iA;
      b_reg      <= iB;
      borrow_reg <= iBorrow;
      cnt        <= '0;
    end else if (state == RUN) begin
      d_reg      <= d_next;
      borrow_reg <= ~slice_sum[BLOCK_WIDTH];
      if (last_slice) begin
        cnt      <= '0;
        zero_reg <= (d_next == '0);
        ovf_reg  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (d_next[WIDTH-1] != a_reg[WIDTH-1]);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign oBusy   = (state != IDLE);
  assign oValid  = (state == DONE);
  assign oBorrow = borrow_reg;
  assign oOvf    = ovf_reg;

`ifdef SUB_SAT_EN
  // Saturation lives purely in the output mux, so DONE timing is unchanged.
  assign oD    = borrow_reg ? '0 : d_reg;
  assign oZero = zero_reg | borrow_reg;
`else
  assign oD    = d_reg;
  assign oZero = zero_reg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_block_serial_subtractor.sv
// Directed testbench for block_serial_subtractor with a scoreboard of
// expected results computed from a reference model at stimulus time.
`default_nettype none

module tb_block_serial_subtractor;

  localparam int WIDTH       = 16;
  localparam int BLOCK_WIDTH = 4;
  localparam int N           = WIDTH / BLOCK_WIDTH;

  logic             iClk;
  logic             iRstN;
  logic             iStart;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iBorrow;
  logic             oBusy;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oD;
  logic             oBorrow;
  logic             oZero;
  logic             oOvf;

  block_serial_subtractor #(
    .WIDTH      (WIDTH),
    .BLOCK_WIDTH(BLOCK_WIDTH)
  ) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iStart (iStart),
    .iA     (iA),
    .iB     (iB),
    .iBorrow(iBorrow),
    .oBusy  (oBusy),
    .oValid (oValid),
    .iReady (iReady),
    .oD     (oD),
    .oBorrow(oBorrow),
    .oZero  (oZero),
    .oOvf   (oOvf)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             borrow;
    logic             zero;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    exp_t         m;
    logic [WIDTH:0] f;
    f        = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    m.d      = f[WIDTH-1:0];
    m.borrow = f[WIDTH];
    m.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
`ifdef SUB_SAT_EN
    if (m.borrow) m.d = '0;
`endif
    m.zero   = (m.d == '0);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the following rising edge is the accept edge.
  task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic bin, input bit push);
    iStart  = 1'b1;
    iA      = a;
    iB      = b;
    iBorrow = bin;
    if (push) sb.push_back(model(a, b, bin));
    @(negedge iClk);
    iStart  = 1'b0;
    iA      = WIDTH'($urandom);
    iB      = WIDTH'($urandom);
    iBorrow = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!oValid && lat < 20) begin
      @(negedge iClk);
      lat++;
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"},  32'(oValid),  32'd1);
      check({tag, "_d"},      32'(oD),      32'(e.d));
      check({tag, "_borrow"}, 32'(oBorrow), 32'(e.borrow));
      check({tag, "_zero"},   32'(oZero),   32'(e.zero));
      check({tag, "_ovf"},    32'(oOvf),    32'(e.ovf));
    end
  endtask

  task automatic handshake_to_idle(input string tag);
    iReady = 1'b1;
    @(negedge iClk);
    iReady = 1'b0;
    check({tag, "_valid_drop"}, 32'(oValid), 32'd0);
    check({tag, "_busy_drop"},  32'(oBusy),  32'd0);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic bin);
    int lat;
    drive_start(a, b, bin, 1'b1);
    check({tag, "_busy"}, 32'(oBusy), 32'd1);
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(N));
    compare_front(tag);
    handshake_to_idle(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int                lat;
    logic [WIDTH+2:0]  hold;

    iRstN   = 1'b0;
    iStart  = 1'b0;
    iA      = '0;
    iB      = '0;
    iBorrow = 1'b0;
    iReady  = 1'b0;
    repeat (2) @(negedge iClk);
    check("rst_busy",   32'(oBusy),   32'd0);
    check("rst_valid",  32'(oValid),  32'd0);
    check("rst_d",      32'(oD),      32'd0);
    check("rst_borrow", 32'(oBorrow), 32'd0);
    check("rst_zero",   32'(oZero),   32'd0);
    check("rst_ovf",    32'(oOvf),    32'd0);
    iRstN = 1'b1;
    @(negedge iClk);

    run_op("basic",    16'h1234, 16'h0234, 1'b0);
    run_op("chain",    16'h0000, 16'h0001, 1'b0);
    run_op("ovf",      16'h8000, 16'h0001, 1'b0);
    run_op("zero",     16'hABCD, 16'hABCD, 1'b0);
    run_op("bin_wrap", 16'h0005, 16'h0005, 1'b1);
    run_op("ovf_neg",  16'h7FFF, 16'hFFFF, 1'b0);
    run_op("mixed",    16'hF0F0, 16'h0F0F, 1'b1);

    // Backpressure, then back-to-back start in the consuming cycle.
    drive_start(16'h1357, 16'h2468, 1'b0, 1'b1);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'(N));
    hold = {oD, oBorrow, oZero, oOvf};
    repeat (5) begin
      @(negedge iClk);
      check("bp_valid_held", 32'(oValid), 32'd1);
      check("bp_out_stable", 32'({oD, oBorrow, oZero, oOvf}), 32'(hold));
    end
    compare_front("bp");
    iReady  = 1'b1;
    iStart  = 1'b1;
    iA      = 16'h0003;
    iB      = 16'h0001;
    iBorrow = 1'b0;
    sb.push_back(model(16'h0003, 16'h0001, 1'b0));
    @(negedge iClk);
    iReady = 1'b0;
    iStart = 1'b0;
    iA     = 16'hFFFF;
    iB     = 16'h1234;
    check("b2b_valid_drop", 32'(oValid), 32'd0);
    check("b2b_busy",       32'(oBusy),  32'd1);
    wait_valid(lat);
    check("b2b_latency", 32'(lat), 32'(N));
    compare_front("b2b");
    handshake_to_idle("b2b");

    // A start pulsed mid-RUN must not disturb the operation in flight.
    drive_start(16'h4000, 16'h0FFF, 1'b0, 1'b1);
    @(negedge iClk);
    iStart  = 1'b1;
    iA      = 16'h0000;
    iB      = 16'hFFFF;
    iBorrow = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    wait_valid(lat);
    check("ign_latency", 32'(lat), 32'(N - 2));
    compare_front("ign");
    handshake_to_idle("ign");

    // Reset mid-RUN aborts without producing a result.
    drive_start(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge iClk);
    iRstN = 1'b0;
    @(negedge iClk);
    iRstN = 1'b1;
    check("midrst_busy",   32'(oBusy),   32'd0);
    check("midrst_valid",  32'(oValid),  32'd0);
    check("midrst_d",      32'(oD),      32'd0);
    check("midrst_borrow", 32'(oBorrow), 32'd0);
    check("midrst_zero",   32'(oZero),   32'd0);
    @(negedge iClk);
    check("midrst_idle_valid", 32'(oValid), 32'd0);

    run_op("fresh", 16'h9000, 16'h1000, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
